// File: rtl/magia_stdio_axi_writer.sv
// Tile-side AXI4 writer for the simulation stdio/exit channel: characters and an
// exit code from the core become single-beat writes to the print-monitor words.

package magia_pkg;
  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_DATA_W = 32;
  localparam int unsigned AXI_ID_W   = 2;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic                  lock;
    logic [3:0]            cache;
    logic [2:0]            prot;
    logic [3:0]            qos;
    logic [3:0]            region;
    logic [5:0]            atop;
    logic                  user;
  } axi_l2_aw_chan_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic                  lock;
    logic [3:0]            cache;
    logic [2:0]            prot;
    logic [3:0]            qos;
    logic [3:0]            region;
    logic                  user;
  } axi_l2_ar_chan_t;

  typedef struct packed {
    logic [AXI_DATA_W-1:0]   data;
    logic [AXI_DATA_W/8-1:0] strb;
    logic                    last;
    logic                    user;
  } axi_l2_w_chan_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0] id;
    logic [1:0]          resp;
    logic                user;
  } axi_l2_b_chan_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_DATA_W-1:0] data;
    logic [1:0]            resp;
    logic                  last;
    logic                  user;
  } axi_l2_r_chan_t;

  typedef struct packed {
    axi_l2_aw_chan_t aw;
    logic            aw_valid;
    axi_l2_w_chan_t  w;
    logic            w_valid;
    logic            b_ready;
    axi_l2_ar_chan_t ar;
    logic            ar_valid;
    logic            r_ready;
  } axi_l2_req_t;

  typedef struct packed {
    logic           aw_ready;
    logic           ar_ready;
    logic           w_ready;
    logic           b_valid;
    axi_l2_b_chan_t b;
    logic           r_valid;
    axi_l2_r_chan_t r;
  } axi_l2_rsp_t;
endpackage

module magia_stdio_axi_writer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] STDIO_BASE = 32'hFFFF_0004,
  parameter logic [31:0] EXIT_ADDR  = 32'hFFFF_0000,
  parameter int unsigned AXI_ID     = 0,
  parameter type axi_req_t = magia_pkg::axi_l2_req_t,
  parameter type axi_rsp_t = magia_pkg::axi_l2_rsp_t
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] hartid_i,
  input  logic        char_valid_i,
  input  logic [7:0]  char_i,
  output logic        char_ready_o,
  input  logic        exit_valid_i,
  input  logic [7:0]  exit_code_i,
  output logic        exit_ready_o,
  output axi_req_t    axi_req_o,
  input  axi_rsp_t    axi_rsp_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_B} state_e;

  axi_req_t req;

  localparam int unsigned ID_W   = $bits(req.aw.id);
  localparam int unsigned SIZE_W = $bits(req.aw.size);
  localparam int unsigned DATA_W = $bits(req.w.data);
  localparam int unsigned STRB_W = $bits(req.w.strb);

  state_e           state_q, state_d;
  logic [7:0]       fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       payload_q, payload_d;
  logic [31:0]      addr_q, addr_d;
  logic             is_exit_q, is_exit_d;
  logic             aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic             exit_pend_q, exit_pend_d;
  logic [7:0]       exit_code_q, exit_code_d;
  logic             done_q, done_d, err_q, err_d;

  logic full, empty, push, bypass, fifo_push, pop, exit_acc;
  logic aw_valid, w_valid, b_ready, aw_fire, w_fire, b_fire;
  logic unused_rsp;

  assign full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty = (count_q == '0);

  // Readies are masked while reset is held so nothing is accepted during it.
  assign char_ready_o = !rst_i && !full && !done_q && !exit_pend_q;
  assign exit_ready_o = !rst_i && !exit_pend_q && !done_q;

  assign push      = char_valid_i && char_ready_o;
  assign exit_acc  = exit_valid_i && exit_ready_o;
  // An idle block with nothing queued loads the char straight into the payload.
  assign bypass    = push && (state_q == IDLE) && empty;
  assign fifo_push = push && !bypass;

  assign aw_fire = aw_valid && axi_rsp_i.aw_ready;
  assign w_fire  = w_valid && axi_rsp_i.w_ready;
  assign b_fire  = b_ready && axi_rsp_i.b_valid;

  assign unused_rsp = ^axi_rsp_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      payload_q   <= '0;
      addr_q      <= '0;
      is_exit_q   <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      exit_pend_q <= 1'b0;
      exit_code_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      payload_q   <= payload_d;
      addr_q      <= addr_d;
      is_exit_q   <= is_exit_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      exit_pend_q <= exit_pend_d;
      exit_code_q <= exit_code_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (fifo_push) fifo_q[wr_ptr_q] <= char_i;
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    payload_d   = payload_q;
    addr_d      = addr_q;
    is_exit_d   = is_exit_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    exit_pend_d = exit_pend_q;
    exit_code_d = exit_code_q;
    done_d      = done_q;
    err_d       = err_q;
    pop         = 1'b0;

    case (state_q)
      IDLE: begin
        // Queued characters always win over the exit write.
        if (!empty) begin
          pop       = 1'b1;
          payload_d = fifo_q[rd_ptr_q];
          addr_d    = STDIO_BASE + (hartid_i << 2);
          is_exit_d = 1'b0;
          state_d   = SEND;
        end else if (bypass) begin
          payload_d = char_i;
          addr_d    = STDIO_BASE + (hartid_i << 2);
          is_exit_d = 1'b0;
          state_d   = SEND;
        end else if (exit_pend_q) begin
          payload_d = exit_code_q;
          addr_d    = EXIT_ADDR;
          is_exit_d = 1'b1;
          state_d   = SEND;
        end
      end
      SEND: begin
        aw_done_d = aw_done_q || aw_fire;
        w_done_d  = w_done_q || w_fire;
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = WAIT_B;
        end
      end
      WAIT_B: begin
        if (b_fire) begin
          state_d = IDLE;
          if (axi_rsp_i.b.resp != 2'b00) err_d = 1'b1;
          if (is_exit_q) begin
            done_d      = 1'b1;
            exit_pend_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (fifo_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)       rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(fifo_push) - CNT_W'(pop);

    if (exit_acc) begin
      exit_pend_d = 1'b1;
      exit_code_d = exit_code_i;
    end
  end

  always_comb begin
    aw_valid = (state_q == SEND) && !aw_done_q;
    w_valid  = (state_q == SEND) && !w_done_q;
    b_ready  = (state_q == WAIT_B);

    req            = '0;
    req.aw_valid   = aw_valid;
    req.aw.id      = ID_W'(AXI_ID);
    req.aw.addr    = addr_q;
    req.aw.len     = '0;
    req.aw.size    = SIZE_W'($clog2(DATA_W / 8));
    req.aw.burst   = 2'b01;
    req.w_valid    = w_valid;
    req.w.data     = DATA_W'(payload_q);
    req.w.strb     = STRB_W'(1);
    req.w.last     = 1'b1;
    req.b_ready    = b_ready;
    req.ar_valid   = 1'b0;
    req.r_ready    = 1'b1;
  end

  assign axi_req_o = req;
  assign busy_o    = !empty || (state_q != IDLE);
  assign done_o    = done_q;
  assign err_o     = err_q;

endmodule
